rr_arb16_ctrl: RTL and testbench

//  Round-robin arbiter that shares one resource among 16 requesters.
//  A registered 4-bit grant index drives an instance of the existing dec4to16

---
 rtl/arb_pkg.sv | 12 +
 rtl/dec4to16.sv | 13 +
 rtl/rr_arb16_ctrl.sv | 116 +++++++++++
 tb/tb_rr_arb16_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and FSM encodings for the 16-way round-robin arbiter
package arb_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dec4to16.sv
// rtl/dec4to16.sv - 4-to-16 one-hot decoder
module dec4to16 (
  input  logic [3:0]  W,
  output logic [15:0] Y
);

  // Exactly one output bit set for every input code
  always_comb begin
    Y    = '0;
    Y[W] = 1'b1;
  end

endmodule

// File: rtl/rr_arb16_ctrl.sv
// rtl/rr_arb16_ctrl.sv - 16-requester round-robin arbiter with bounded grant tenure
module rr_arb16_ctrl
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic                 done,
  output logic                 gnt_valid,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic [N_REQ-1:0]     gnt_onehot,
  output logic                 timeout
);

  localparam int HCW = $clog2(HOLD_MAX + 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_MAX - 1);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [HCW-1:0]     hold_cnt_q, hold_cnt_d;
  logic               timeout_q, timeout_d;

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]   win_off;
  logic [IDX_W-1:0]   win_idx;
  logic               hit_max;
  logic               cur_req;
  logic               rel_cond;
  logic [N_REQ-1:0]   dec_y;

  // Next winner: rotate so ptr sits at bit 0, take the lowest set bit, map back
  always_comb begin
    req_dbl = {req, req} >> ptr_q;
    req_rot = req_dbl[N_REQ-1:0];
    win_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_off = IDX_W'(i);
      end
    end
    win_idx = ptr_q + win_off;
  end

  // Next-state and register updates; release always returns to IDLE for one bubble
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
    hit_max     = (hold_cnt_q == HOLD_LAST);
    cur_req     = req[gnt_idx_q];
    rel_cond    = done | ~cur_req | hit_max;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
          state_d     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (rel_cond) begin
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + IDX_W'(1);
          state_d     = ST_IDLE;
          // Expiry is flagged only when nothing else would have ended the grant
          timeout_d   = hit_max & ~done & cur_req;
        end else begin
          hold_cnt_d  = hold_cnt_q + HCW'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset that drops any grant in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  dec4to16 u_dec (
    .W (gnt_idx_q),
    .Y (dec_y)
  );

  assign gnt_valid  = gnt_valid_q;
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = dec_y & {N_REQ{gnt_valid_q}};
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_rr_arb16_ctrl.sv
// tb/tb_rr_arb16_ctrl.sv - directed vector bench for rr_arb16_ctrl
module tb_rr_arb16_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic        gnt_valid;
  logic [3:0]  gnt_idx;
  logic [15:0] gnt_onehot;
  logic        timeout;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic        exp_valid;
    logic [3:0]  exp_idx;
    logic [15:0] exp_oh;
    logic        exp_to;
  } vec_t;

  vec_t vecs[$];

  rr_arb16_ctrl #(.HOLD_MAX(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .timeout    (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [15:0] q, input logic d);
    rst  = r;
    req  = q;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input logic r, input logic [15:0] q, input logic d,
                      input logic ev, input logic [3:0] ei, input logic [15:0] eo,
                      input logic et);
    vec_t v;
    v.rst = r; v.req = q; v.done = d;
    v.exp_valid = ev; v.exp_idx = ei; v.exp_oh = eo; v.exp_to = et;
    vecs.push_back(v);
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [3:0] ei,
                         input logic [15:0] eo, input logic et);
    chk({tag, "_valid"}, 32'(gnt_valid), 32'(ev));
    chk({tag, "_idx"}, 32'(gnt_idx), 32'(ei));
    chk({tag, "_onehot"}, 32'(gnt_onehot), 32'(eo));
    chk({tag, "_timeout"}, 32'(timeout), 32'(et));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;

    // reset, then idle with no requests
    addv(1, 16'h0000, 0, 0, 4'd0, 16'h0000, 0);
    for (int i = 0; i < 10; i++) addv(0, 16'h0000, 0, 0, 4'd0, 16'h0000, 0);
    // single requester 0, three grant cycles, then done
    addv(0, 16'h0001, 0, 1, 4'd0, 16'h0001, 0);
    addv(0, 16'h0001, 0, 1, 4'd0, 16'h0001, 0);
    addv(0, 16'h0001, 0, 1, 4'd0, 16'h0001, 0);
    addv(0, 16'h0001, 1, 0, 4'd0, 16'h0000, 0);
    // ptr now 1: requester 1 beats requester 0
    addv(0, 16'h0003, 0, 1, 4'd1, 16'h0002, 0);
    addv(0, 16'h0000, 0, 0, 4'd1, 16'h0000, 0);
    // ptr now 2: grant 5, then req5 drops while req9 rises
    addv(0, 16'h0020, 0, 1, 4'd5, 16'h0020, 0);
    addv(0, 16'h0020, 0, 1, 4'd5, 16'h0020, 0);
    addv(0, 16'h0200, 0, 0, 4'd5, 16'h0000, 0);
    addv(0, 16'h0200, 0, 1, 4'd9, 16'h0200, 0);
    addv(0, 16'h0220, 1, 0, 4'd9, 16'h0000, 0);
    // ptr now 10: scan wraps past 15 to reach 5
    addv(0, 16'h0220, 0, 1, 4'd5, 16'h0020, 0);
    for (int i = 0; i < 4; i++) addv(0, 16'h0220, 0, 1, 4'd5, 16'h0020, 0);
    // reset with hold count at 4, then ptr restarts from 0
    addv(1, 16'h0220, 0, 0, 4'd0, 16'h0000, 0);
    addv(0, 16'h0004, 0, 1, 4'd2, 16'h0004, 0);
    addv(0, 16'h0000, 0, 0, 4'd2, 16'h0000, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].done);
      chk_out($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_idx,
              vecs[i].exp_oh, vecs[i].exp_to);
    end

    // full rotation with done every grant, including the 15->0 wrap
    step(1, 16'h0000, 0);
    for (int i = 0; i <= 16; i++) begin
      step(0, 16'hFFFF, 1);
      chk_out($sformatf("rot%0d_g", i), 1'b1, 4'(i % 16), 16'(1 << (i % 16)), 1'b0);
      step(0, 16'hFFFF, 1);
      chk($sformatf("rot%0d_bubble", i), 32'(gnt_valid), 32'd0);
      chk($sformatf("rot%0d_bubble_to", i), 32'(timeout), 32'd0);
    end

    // tenure expiry: requester 0 never releases
    step(1, 16'h0000, 0);
    for (int k = 0; k < 8; k++) begin
      step(0, 16'h8001, 0);
      chk_out($sformatf("exp%0d", k), 1'b1, 4'd0, 16'h0001, 1'b0);
    end
    step(0, 16'h8001, 0);
    chk_out("exp_rel", 1'b0, 4'd0, 16'h0000, 1'b1);
    step(0, 16'h8001, 0);
    chk_out("exp_next", 1'b1, 4'd15, 16'h8000, 1'b0);
    for (int k = 1; k < 8; k++) begin
      step(0, 16'h8001, 0);
      chk_out($sformatf("hold15_%0d", k), 1'b1, 4'd15, 16'h8000, 1'b0);
    end
    // done on the last tenure cycle wins over expiry
    step(0, 16'h8001, 1);
    chk_out("done_prio", 1'b0, 4'd15, 16'h0000, 1'b0);
    step(0, 16'h8001, 0);
    chk_out("after_wrap", 1'b1, 4'd0, 16'h0001, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
